// File: rtl/branch_control.sv
// Branch/jump sequencing controller: decodes a 9-bit instruction stream and
// issues one-cycle registered control pulses, with a one-cycle flush after each transfer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; init_ctrl held high, instruction ignored
// S_RUN   | decoding one instruction per edge
// S_FLUSH | one-cycle bubble after a taken BZ or a JMP
// S_HALT  | halted; done_ctrl held high until reset
module branch_control #(
  parameter int BR_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instruction,
  input  logic [BR_W-1:0] instruction_number,
  input  logic            flag,
  output logic            branch_ctrl,
  output logic            jump_ctrl,
  output logic            init_ctrl,
  output logic            done_ctrl,
  output logic [BR_W-1:0] branch_val,
  output logic [BR_W-1:0] jump_val,
  output logic [7:0]      taken_count,
  output logic [BR_W-1:0] last_pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

  localparam logic [2:0] OP_HALT = 3'b100;
  localparam logic [2:0] OP_SETB = 3'b101;
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  state_t state, state_nxt;

  logic [2:0] opcode;
  logic [5:0] imm6;
  logic       is_setb, is_bz_taken, is_jmp, is_halt;

  logic            branch_nxt, jump_nxt, init_nxt, done_nxt;
  logic [BR_W-1:0] breg_nxt, jval_nxt, lpc_nxt;
  logic [7:0]      cnt_nxt;

  assign opcode      = instruction[8:6];
  assign imm6        = instruction[5:0];
  assign is_setb     = (opcode == OP_SETB);
  assign is_bz_taken = (opcode == OP_BZ) && flag;
  assign is_jmp      = (opcode == OP_JMP);
  assign is_halt     = (opcode == OP_HALT) && (imm6 == 6'd0);

  // State and all registered outputs share one async-reset register bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      branch_ctrl <= 1'b0;
      jump_ctrl   <= 1'b0;
      init_ctrl   <= 1'b1;
      done_ctrl   <= 1'b0;
      branch_val  <= '0;
      jump_val    <= '0;
      taken_count <= 8'd0;
      last_pc     <= '0;
    end else begin
      state       <= state_nxt;
      branch_ctrl <= branch_nxt;
      jump_ctrl   <= jump_nxt;
      init_ctrl   <= init_nxt;
      done_ctrl   <= done_nxt;
      branch_val  <= breg_nxt;
      jump_val    <= jval_nxt;
      taken_count <= cnt_nxt;
      last_pc     <= lpc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (is_bz_taken || is_jmp) state_nxt = S_FLUSH;
        else if (is_halt)          state_nxt = S_HALT;
      end
      S_FLUSH: state_nxt = S_RUN;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; only RUN acts on the instruction.
  always_comb begin
    branch_nxt = 1'b0;
    jump_nxt   = 1'b0;
    init_nxt   = (state_nxt == S_IDLE);
    done_nxt   = (state_nxt == S_HALT);
    breg_nxt   = branch_val;
    jval_nxt   = jump_val;
    cnt_nxt    = taken_count;
    lpc_nxt    = last_pc;
    if (state == S_RUN) begin
      if (is_setb)
        breg_nxt = {{(BR_W-6){imm6[5]}}, imm6};
      if (is_bz_taken)
        branch_nxt = 1'b1;
      if (is_jmp) begin
        jump_nxt = 1'b1;
        jval_nxt = {{(BR_W-6){1'b0}}, imm6};
      end
      if (is_bz_taken || is_jmp) begin
        lpc_nxt = instruction_number;
        if (taken_count != 8'hFF)
          cnt_nxt = taken_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_control.sv
// Directed bench for branch_control: a vector table for the main sequence plus
// hand-written sequences for async reset, saturation and reset during FLUSH.
module tb_branch_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] instruction;
  logic [7:0] instruction_number;
  logic       flag;
  logic       branch_ctrl, jump_ctrl, init_ctrl, done_ctrl;
  logic [7:0] branch_val, jump_val, taken_count, last_pc;

  int checks = 0;
  int errors = 0;

  branch_control #(.BR_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .instruction_number(instruction_number), .flag(flag),
    .branch_ctrl(branch_ctrl), .jump_ctrl(jump_ctrl), .init_ctrl(init_ctrl),
    .done_ctrl(done_ctrl), .branch_val(branch_val), .jump_val(jump_val),
    .taken_count(taken_count), .last_pc(last_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic [8:0] instr;
    logic       flag;
    logic [7:0] pc;
    logic       e_br, e_jp, e_init, e_done;
    logic [7:0] e_bval, e_jval, e_cnt, e_lpc;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic s, logic [8:0] i, logic f, logic [7:0] p,
                              logic br, logic jp, logic in, logic dn,
                              logic [7:0] bv, logic [7:0] jv, logic [7:0] c, logic [7:0] lp);
    vec_t v;
    v.start = s; v.instr = i; v.flag = f; v.pc = p;
    v.e_br = br; v.e_jp = jp; v.e_init = in; v.e_done = dn;
    v.e_bval = bv; v.e_jval = jv; v.e_cnt = c; v.e_lpc = lp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " branch_ctrl"}, {7'd0, branch_ctrl}, 8'd0);
    chk({tag, " jump_ctrl"},   {7'd0, jump_ctrl},   8'd0);
    chk({tag, " done_ctrl"},   {7'd0, done_ctrl},   8'd0);
    chk({tag, " init_ctrl"},   {7'd0, init_ctrl},   8'd1);
    chk({tag, " branch_val"},  branch_val,  8'h00);
    chk({tag, " jump_val"},    jump_val,    8'h00);
    chk({tag, " taken_count"}, taken_count, 8'd0);
    chk({tag, " last_pc"},     last_pc,     8'h00);
  endtask

  initial begin
    //                 st  instr   f  pc     br jp in dn bval   jval   cnt    lpc
    vecs[0]  = mk(1'b0, 9'h000, 1'b0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 8'd0, 8'h00);
    vecs[1]  = mk(1'b1, 9'h000, 1'b0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'd0, 8'h00);
    vecs[2]  = mk(1'b0, 9'h17E, 1'b0, 8'h01, 0, 0, 0, 0, 8'hFE, 8'h00, 8'd0, 8'h00);
    vecs[3]  = mk(1'b0, 9'h180, 1'b1, 8'h10, 1, 0, 0, 0, 8'hFE, 8'h00, 8'd1, 8'h10);
    vecs[4]  = mk(1'b0, 9'h141, 1'b0, 8'h11, 0, 0, 0, 0, 8'hFE, 8'h00, 8'd1, 8'h10);
    vecs[5]  = mk(1'b0, 9'h180, 1'b0, 8'h12, 0, 0, 0, 0, 8'hFE, 8'h00, 8'd1, 8'h10);
    vecs[6]  = mk(1'b1, 9'h180, 1'b1, 8'h13, 1, 0, 0, 0, 8'hFE, 8'h00, 8'd2, 8'h13);
    vecs[7]  = mk(1'b0, 9'h000, 1'b0, 8'h14, 0, 0, 0, 0, 8'hFE, 8'h00, 8'd2, 8'h13);
    vecs[8]  = mk(1'b0, 9'h1EA, 1'b0, 8'h20, 0, 1, 0, 0, 8'hFE, 8'h2A, 8'd3, 8'h20);
    vecs[9]  = mk(1'b0, 9'h100, 1'b0, 8'h21, 0, 0, 0, 0, 8'hFE, 8'h2A, 8'd3, 8'h20);
    vecs[10] = mk(1'b0, 9'h180, 1'b1, 8'h22, 1, 0, 0, 0, 8'hFE, 8'h2A, 8'd4, 8'h22);
    vecs[11] = mk(1'b0, 9'h000, 1'b0, 8'h23, 0, 0, 0, 0, 8'hFE, 8'h2A, 8'd4, 8'h22);
    vecs[12] = mk(1'b0, 9'h101, 1'b0, 8'h24, 0, 0, 0, 0, 8'hFE, 8'h2A, 8'd4, 8'h22);
    vecs[13] = mk(1'b0, 9'h160, 1'b0, 8'h25, 0, 0, 0, 0, 8'hE0, 8'h2A, 8'd4, 8'h22);
    vecs[14] = mk(1'b0, 9'h100, 1'b0, 8'h26, 0, 0, 0, 1, 8'hE0, 8'h2A, 8'd4, 8'h22);
    vecs[15] = mk(1'b1, 9'h1EA, 1'b1, 8'h30, 0, 0, 0, 1, 8'hE0, 8'h2A, 8'd4, 8'h22);
    vecs[16] = mk(1'b0, 9'h180, 1'b1, 8'h31, 0, 0, 0, 1, 8'hE0, 8'h2A, 8'd4, 8'h22);

    reset = 1'b1; start = 1'b0; instruction = 9'h000; instruction_number = 8'h00; flag = 1'b0;
    #1;
    chk_reset_values("por");
    #11;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start; instruction = vecs[i].instr;
      flag = vecs[i].flag; instruction_number = vecs[i].pc;
      step();
      chk($sformatf("v%0d branch_ctrl", i), {7'd0, branch_ctrl}, {7'd0, vecs[i].e_br});
      chk($sformatf("v%0d jump_ctrl", i),   {7'd0, jump_ctrl},   {7'd0, vecs[i].e_jp});
      chk($sformatf("v%0d init_ctrl", i),   {7'd0, init_ctrl},   {7'd0, vecs[i].e_init});
      chk($sformatf("v%0d done_ctrl", i),   {7'd0, done_ctrl},   {7'd0, vecs[i].e_done});
      chk($sformatf("v%0d branch_val", i),  branch_val,  vecs[i].e_bval);
      chk($sformatf("v%0d jump_val", i),    jump_val,    vecs[i].e_jval);
      chk($sformatf("v%0d taken_count", i), taken_count, vecs[i].e_cnt);
      chk($sformatf("v%0d last_pc", i),     last_pc,     vecs[i].e_lpc);
      chk($sformatf("v%0d exclusive", i),
          {6'd0, 2'($countones({branch_ctrl, jump_ctrl, done_ctrl}))} <= 8'd1 ? 8'd1 : 8'd0, 8'd1);
    end

    // Reset in the middle of a HALT cycle must clear outputs before the next edge.
    start = 1'b0; instruction = 9'h000; flag = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_values("halt_reset");
    #2 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle%0d init_ctrl", i), {7'd0, init_ctrl}, 8'd1);
    end
    start = 1'b1;
    step();
    chk("start init_ctrl", {7'd0, init_ctrl}, 8'd0);
    start = 1'b0;

    // Saturation: 300 JMP/filler pairs.
    for (int i = 0; i < 300; i++) begin
      instruction = 9'h1C5; instruction_number = 8'(i);
      step();
      chk($sformatf("sat%0d jump_ctrl", i), {7'd0, jump_ctrl}, 8'd1);
      chk($sformatf("sat%0d taken_count", i), taken_count, (i < 255) ? 8'(i + 1) : 8'd255);
      instruction = 9'h000;
      step();
    end
    chk("sat last_pc", last_pc, 8'(299));
    chk("sat jump_val", jump_val, 8'h05);

    // Reset during FLUSH leaves no residual pulse.
    instruction = 9'h1EA; instruction_number = 8'h77;
    step();
    chk("preflush jump_ctrl", {7'd0, jump_ctrl}, 8'd1);
    #2 reset = 1'b1;
    #1 chk_reset_values("flush_reset");
    #2 reset = 1'b0;
    step();
    chk("post_flush_reset init_ctrl", {7'd0, init_ctrl}, 8'd1);
    chk("post_flush_reset jump_ctrl", {7'd0, jump_ctrl}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_control.md
BRANCH_CONTROL -- requirements
Module: branch_control

Interface
REQ-001 The block SHALL have one parameter: BR_W, default 8, the width of the branch register, branch_val, jump_val and instruction_number.
REQ-002 clock  in  1  single clock; all state SHALL update on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that leaves IDLE.
REQ-005 instruction  in  9  fetched instruction word; opcode is [8:6], imm6 is [5:0].
REQ-006 instruction_number  in  BR_W  PC of the instruction; captured for trace only.
REQ-007 flag  in  1  compare flag; sampled on the same edge as the instruction.
REQ-008 branch_ctrl  out  1  registered; one cycle per taken BZ.
REQ-009 jump_ctrl  out  1  registered; one cycle per JMP.
REQ-010 init_ctrl  out  1  registered; PC-clear request.
REQ-011 done_ctrl  out  1  registered; halt indication.
REQ-012 branch_val  out  BR_W  current value of the branch register.
REQ-013 jump_val  out  BR_W  registered absolute jump target.
REQ-014 taken_count  out  8  saturating count of taken branches plus jumps.
REQ-015 last_pc  out  BR_W  instruction_number of the most recent taken control transfer.

Function
REQ-016 Decode SHALL be as follows:
- SETB 3'b101: branch register <= sign-extended imm6.
- BZ 3'b110: taken if flag==1.
- JMP 3'b111: target = zero-extended imm6.
- HALT 3'b100 with imm6==0.
- Any other word is a no-op.
REQ-017 The state machine SHALL have four states: IDLE, RUN, FLUSH, HALT.
REQ-018 IDLE: init_ctrl=1, all other control outputs 0, instruction ignored; start=1 -> RUN on the next edge, and init_ctrl drops with that transition.
REQ-019 RUN, per edge:
- Taken BZ: branch_ctrl=1 for the following cycle, -> FLUSH.
- JMP: jump_ctrl=1 and jump_val=target for the following cycle, -> FLUSH.
- HALT: done_ctrl=1, -> HALT.
- Otherwise: stay in RUN, controls 0.
REQ-020 FLUSH SHALL last exactly one cycle, ignore the instruction (including SETB/HALT), force controls to 0, and then return to RUN.
REQ-021 HALT SHALL hold done_ctrl=1 and ignore start and instruction until reset.
REQ-022 branch_ctrl, jump_ctrl and done_ctrl SHALL be mutually exclusive in every cycle.
REQ-023 A not-taken BZ (flag=0) SHALL behave as a no-op with no FLUSH.
REQ-024 SETB in RUN SHALL update the branch register on that edge, and branch_val SHALL reflect the new value from the next cycle.
REQ-025 A BZ on the instruction immediately after SETB SHALL use the updated value.
REQ-026 Branch register arithmetic SHALL be two's complement, BR_W bits; sign-extension replicates imm6[5].
REQ-027 On a taken BZ or JMP, taken_count SHALL increment by 1 and saturate at 255 (no wrap).
REQ-028 On a taken BZ or JMP, last_pc SHALL capture instruction_number.
REQ-029 start asserted while in RUN, FLUSH or HALT SHALL have no effect.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state=IDLE
- branch register=0, jump_val=0, last_pc=0, taken_count=0
- branch_ctrl=jump_ctrl=done_ctrl=0
- init_ctrl=1
REQ-031 Reset asserted mid-FLUSH or mid-HALT SHALL yield the same reset values with no residual control pulse.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-033 Reset, then start pulse -> init_ctrl 1 until the start edge, then 0; state RUN; all other outputs 0.
REQ-034 SETB imm6=6'h3E, then BZ flag=1 -> branch_val=8'hFE from the cycle after SETB; branch_ctrl=1 for exactly one cycle; next instruction ignored; taken_count=1; last_pc equals the BZ instruction_number.
REQ-035 JMP imm6=6'h2A followed by HALT in the FLUSH slot -> jump_ctrl=1 with jump_val=8'h2A for one cycle; HALT ignored; state returns to RUN.
REQ-036 BZ with flag=0 -> no branch_ctrl, no FLUSH, taken_count unchanged.
REQ-037 300 consecutive JMP/filler pairs -> taken_count saturates at 255.
REQ-038 HALT, then start and JMP -> done_ctrl stays 1, no jump_ctrl; async reset mid-cycle clears done_ctrl before the next edge.
